// File: rtl/plic_pkg.sv
// plic_pkg: shared definitions for the PLIC interrupt gateway.
//   ID_W       - width of claim/complete source IDs
//   MAX_SRC    - largest source ID the ID width can address (ID 0 reserved)
//   gw_state_t - per-source gateway state
package plic_pkg;

    localparam int unsigned ID_W    = 5;
    localparam int unsigned MAX_SRC = 31;

    typedef enum logic [1:0] {
        GW_IDLE = 2'd0,
        GW_REQ  = 2'd1,
        GW_INFL = 2'd2
    } gw_state_t;

endpackage

// File: rtl/plic_gateway_src.sv
// plic_gateway_src: gateway for one interrupt source.
//   Synchronises the raw line, optionally glitch-filters it, applies level or
//   rising-edge semantics and holds one outstanding request until the PLIC
//   claim/complete handshake retires it. Edge sources count missed edges in a
//   saturating counter and re-request after each completion.
// Optional build macro: PLIC_GATEWAY_GLITCH_FILTER_EN (stability filter after
//   the synchroniser; adds FILT_CYCLES of latency).
// Ports:
//   clk, resetn    - clock, synchronous active-low reset
//   irq_raw        - asynchronous raw source line
//   edge_mode      - 1 = rising-edge source, 0 = level-high source
//   match_claim    - claim of this source's ID this cycle
//   match_complete - complete of this source's ID this cycle
//   irq_out        - registered request to the PLIC core
//   inflight       - registered status: claimed, not yet completed
module plic_gateway_src
    import plic_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_CNT_W  = 3,
    parameter int unsigned FILT_CYCLES = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic irq_raw,
    input  logic edge_mode,
    input  logic match_claim,
    input  logic match_complete,
    output logic irq_out,
    output logic inflight
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic                   filt;
    logic                   prev;
    logic                   rise;
    logic [EDGE_CNT_W-1:0]  cnt;
    logic                   cnt_sat;
    gw_state_t              state;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_raw};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

`ifdef PLIC_GATEWAY_GLITCH_FILTER_EN
    localparam int unsigned FW = $clog2(FILT_CYCLES + 1);

    logic [FW-1:0] filt_cnt;

    // filt only follows sync after FILT_CYCLES consecutive disagreeing cycles
    always_ff @(posedge clk) begin
        if (!resetn) begin
            filt     <= 1'b0;
            filt_cnt <= '0;
        end else if (sync != filt) begin
            if (filt_cnt == FW'(FILT_CYCLES - 1)) begin
                filt     <= sync;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end else begin
            filt_cnt <= '0;
        end
    end
`else
    assign filt = sync;
`endif

    assign rise    = filt & ~prev;
    assign cnt_sat = (cnt == '1);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= GW_IDLE;
            cnt      <= '0;
            prev     <= 1'b0;
            irq_out  <= 1'b0;
            inflight <= 1'b0;
        end else begin
            prev <= filt;
            case (state)
                GW_IDLE: begin
                    if (edge_mode) begin
                        if (cnt != '0) begin
                            // a coincident rise replaces the edge being consumed
                            state   <= GW_REQ;
                            irq_out <= 1'b1;
                            if (!rise) begin
                                cnt <= cnt - 1'b1;
                            end
                        end else if (rise) begin
                            state   <= GW_REQ;
                            irq_out <= 1'b1;
                        end
                    end else if (filt) begin
                        state   <= GW_REQ;
                        irq_out <= 1'b1;
                    end
                end
                GW_REQ: begin
                    if (match_claim) begin
                        state    <= GW_INFL;
                        irq_out  <= 1'b0;
                        inflight <= 1'b1;
                    end else if (!edge_mode && !filt) begin
                        state   <= GW_IDLE;
                        irq_out <= 1'b0;
                    end
                    if (edge_mode && rise && !cnt_sat) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GW_INFL: begin
                    if (match_complete) begin
                        state    <= GW_IDLE;
                        inflight <= 1'b0;
                    end
                    if (edge_mode && rise && !cnt_sat) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= GW_IDLE;
                    irq_out  <= 1'b0;
                    inflight <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/plic_gateway.sv
// plic_gateway: per-source interrupt gateways feeding the PLIC core's
//   interrupt_request vector. Decodes the claim/complete IDs into per-source
//   match pulses and instantiates one plic_gateway_src per source ID 1..NUM_SRC.
// Optional build macro: PLIC_GATEWAY_GLITCH_FILTER_EN (see plic_gateway_src).
// Ports:
//   clk, resetn    - clock, synchronous active-low reset
//   irq_raw        - asynchronous source lines, bit k-1 is source k
//   edge_mode      - per source: 1 = rising-edge, 0 = level-high
//   claim_valid    - claim register read pulse, claim_id = returned ID
//   complete_valid - complete write pulse, complete_id = written ID
//   irq_out        - registered gated requests to the PLIC
//   inflight       - registered per-source claimed-not-completed status
module plic_gateway
    import plic_pkg::*;
#(
    parameter int unsigned NUM_SRC     = 31,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_CNT_W  = 3,
    parameter int unsigned FILT_CYCLES = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [NUM_SRC-1:0] irq_raw,
    input  logic [NUM_SRC-1:0] edge_mode,
    input  logic               claim_valid,
    input  logic [ID_W-1:0]    claim_id,
    input  logic               complete_valid,
    input  logic [ID_W-1:0]    complete_id,
    output logic [NUM_SRC-1:0] irq_out,
    output logic [NUM_SRC-1:0] inflight
);

    logic [NUM_SRC-1:0] match_claim;
    logic [NUM_SRC-1:0] match_complete;

    // IDs 0 and >NUM_SRC never match any source, so they have no effect
    for (genvar k = 1; k <= NUM_SRC; k++) begin : g_src
        assign match_claim[k-1]    = claim_valid    && (claim_id    == ID_W'(k));
        assign match_complete[k-1] = complete_valid && (complete_id == ID_W'(k));

        plic_gateway_src #(
            .SYNC_STAGES (SYNC_STAGES),
            .EDGE_CNT_W  (EDGE_CNT_W),
            .FILT_CYCLES (FILT_CYCLES)
        ) u_src (
            .clk            (clk),
            .resetn         (resetn),
            .irq_raw        (irq_raw[k-1]),
            .edge_mode      (edge_mode[k-1]),
            .match_claim    (match_claim[k-1]),
            .match_complete (match_complete[k-1]),
            .irq_out        (irq_out[k-1]),
            .inflight       (inflight[k-1])
        );
    end

endmodule
